// File: rtl/mips32_fetch_queue.sv
// Fetch front-end: owns the PC, issues one imem read per cycle and queues {ir, pc+1} for IF/ID.
// Request-to-out_valid latency is 2 cycles; issue is credit-limited so a response always finds space.
module mips32_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_ir,
  output logic [31:0]       out_npc,
  output logic [31:0]       fetch_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   CREDIT_LIM = (CNT_W + 1)'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      ir_mem_q  [DEPTH];
  logic [31:0]      npc_mem_q [DEPTH];

  logic             push;
  logic             pop;
  logic [CNT_W:0]   used;
  logic [31:0]      push_npc;

  // Occupancy plus the outstanding read must leave room, so a response never meets a full queue.
  assign used      = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign imem_req  = rst_n && !redirect && !halt && (used < CREDIT_LIM);
  assign imem_addr = pc_q[ADDR_W-1:0];
  assign fetch_pc  = pc_q;

  assign out_valid = (count_q != '0);
  assign out_ir    = ir_mem_q[rd_ptr_q];
  assign out_npc   = npc_mem_q[rd_ptr_q];

  assign push      = inflight_q && !redirect;
  assign pop       = out_valid && out_ready;
  assign push_npc  = req_pc_q + 32'd1;

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (imem_req) begin
      pc_d     = pc_q + 32'd1;
      req_pc_d = pc_q;
    end

    if (redirect) begin
      // Wrong-path entries and the arriving response are dropped; a same-cycle pop is still handed over.
      pc_d     = redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem_q[i]  <= '0;
        npc_mem_q[i] <= '0;
      end
    end else if (push) begin
      ir_mem_q[wr_ptr_q]  <= imem_rdata;
      npc_mem_q[wr_ptr_q] <= push_npc;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst_n && push) begin
      assert (count_q != FULL_CNT);
    end
  end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Directed bench for mips32_fetch_queue; inputs and checks happen at the falling edge of clk1.
module tb_mips32_fetch_queue;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ir;
  logic [31:0] out_npc;
  logic [31:0] fetch_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk1 = ~clk1;

  // Synchronous instruction memory: word k holds 0x1000_0000 + k.
  always @(posedge clk1) imem_rdata <= 32'h1000_0000 + {22'd0, imem_addr};

  mips32_fetch_queue #(.DEPTH(4), .ADDR_W(10)) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ir      (out_ir),
    .out_npc     (out_npc),
    .fetch_pc    (fetch_pc)
  );

  // Leaves the bench at the falling edge that starts cycle 0 with rst_n released.
  task automatic do_reset();
    rst_n       = 1'b0;
    out_ready   = 1'b0;
    halt        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    @(negedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    out_ready   = 1'b1;
    halt        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    @(negedge clk1);
    @(negedge clk1);
    #1;
    total++;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_imem_req got=%0b want=0", imem_req); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++;
    if (out_ir !== 32'd0 || out_npc !== 32'd0) begin
      bad++; $display("FAIL reset_head got=%0h/%0h want=0/0", out_ir, out_npc);
    end
    total++;
    if (fetch_pc !== 32'd0 || imem_addr !== 10'd0) begin
      bad++; $display("FAIL reset_pc got=%0h/%0h want=0/0", fetch_pc, imem_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 10'(c)) begin
        bad++; $display("FAIL stream_req c=%0d got=%0b/%0h want=1/%0h", c, imem_req, imem_addr, c);
      end
      total++;
      if (c < 2) begin
        if (out_valid !== 1'b0) begin
          bad++; $display("FAIL stream_early_valid c=%0d got=%0b want=0", c, out_valid);
        end
      end else if (out_valid !== 1'b1 || out_ir !== 32'h1000_0000 + 32'(c - 2) || out_npc !== 32'(c - 1)) begin
        bad++; $display("FAIL stream_data c=%0d got=%0b/%0h/%0h want=1/%0h/%0h",
                        c, out_valid, out_ir, out_npc, 32'h1000_0000 + 32'(c - 2), c - 1);
      end
      @(negedge clk1);
    end
  endtask

  task automatic test_backpressure();
    int nreq;
    nreq = 0;
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (imem_req === 1'b1) nreq++;
      if (c >= 4) begin
        total++;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_stop c=%0d got=%0b want=0", c, imem_req); end
      end
      if (c >= 2) begin
        total++;
        if (out_valid !== 1'b1 || out_ir !== 32'h1000_0000) begin
          bad++; $display("FAIL bp_head c=%0d got=%0b/%0h want=1/10000000", c, out_valid, out_ir);
        end
      end
      @(negedge clk1);
    end
    total++;
    if (nreq != 4) begin bad++; $display("FAIL bp_req_count got=%0d want=4", nreq); end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      total++;
      if (out_valid !== 1'b1 || out_ir !== 32'h1000_0000 + 32'(k) || out_npc !== 32'(k + 1)) begin
        bad++; $display("FAIL bp_drain k=%0d got=%0b/%0h/%0h want=1/%0h/%0h",
                        k, out_valid, out_ir, out_npc, 32'h1000_0000 + 32'(k), k + 1);
      end
      @(negedge clk1);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b0;
    repeat (4) @(negedge clk1);
    // Cycle 4: three entries queued, word 3 in flight.
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    #1;
    total++;
    if (imem_req !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL redir_cycle got=req%0b/vld%0b want=0/1", imem_req, out_valid);
    end
    @(negedge clk1);
    redirect  = 1'b0;
    out_ready = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 10'h40 || fetch_pc !== 32'h40) begin
      bad++; $display("FAIL redir_r1 got=%0b/%0b/%0h/%0h want=0/1/40/40", out_valid, imem_req, imem_addr, fetch_pc);
    end
    @(negedge clk1);
    #1;
    total++;
    if (out_valid !== 1'b0 || imem_addr !== 10'h41) begin
      bad++; $display("FAIL redir_r2 got=%0b/%0h want=0/41", out_valid, imem_addr);
    end
    @(negedge clk1);
    #1;
    total++;
    if (out_valid !== 1'b1 || out_ir !== 32'h1000_0040 || out_npc !== 32'h41) begin
      bad++; $display("FAIL redir_r3 got=%0b/%0h/%0h want=1/10000040/41", out_valid, out_ir, out_npc);
    end
    @(negedge clk1);
    #1;
    total++;
    if (out_valid !== 1'b1 || out_ir !== 32'h1000_0041 || out_npc !== 32'h42) begin
      bad++; $display("FAIL redir_r4 got=%0b/%0h/%0h want=1/10000041/42", out_valid, out_ir, out_npc);
    end
    @(negedge clk1);
  endtask

  task automatic test_halt();
    do_reset();
    out_ready = 1'b0;
    repeat (3) @(negedge clk1);
    // Cycle 3: two entries queued, word 2 in flight.
    halt      = 1'b1;
    out_ready = 1'b1;
    for (int c = 3; c < 10; c++) begin
      #1;
      total++;
      if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_req c=%0d got=%0b want=0", c, imem_req); end
      total++;
      if (c <= 5) begin
        if (out_valid !== 1'b1 || out_ir !== 32'h1000_0000 + 32'(c - 3)) begin
          bad++; $display("FAIL halt_drain c=%0d got=%0b/%0h want=1/%0h", c, out_valid, out_ir, 32'h1000_0000 + 32'(c - 3));
        end
      end else if (out_valid !== 1'b0) begin
        bad++; $display("FAIL halt_empty c=%0d got=%0b want=0", c, out_valid);
      end
      @(negedge clk1);
    end
    halt = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 10'd3) begin
      bad++; $display("FAIL halt_resume got=%0b/%0h want=1/3", imem_req, imem_addr);
    end
    @(negedge clk1);
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    repeat (2) @(negedge clk1);
    redirect    = 1'b1;
    redirect_pc = 32'h3FF;
    @(negedge clk1);
    redirect = 1'b0;
    #1;
    total++;
    if (imem_addr !== 10'h3FF || fetch_pc !== 32'h3FF) begin
      bad++; $display("FAIL wrap_a0 got=%0h/%0h want=3ff/3ff", imem_addr, fetch_pc);
    end
    @(negedge clk1);
    #1;
    total++;
    if (imem_addr !== 10'h000 || fetch_pc !== 32'h400) begin
      bad++; $display("FAIL wrap_a1 got=%0h/%0h want=0/400", imem_addr, fetch_pc);
    end
    @(negedge clk1);
    #1;
    total++;
    if (imem_addr !== 10'h001 || out_valid !== 1'b1 || out_ir !== 32'h1000_03FF || out_npc !== 32'h400) begin
      bad++; $display("FAIL wrap_d0 got=%0h/%0b/%0h/%0h want=1/1/100003ff/400", imem_addr, out_valid, out_ir, out_npc);
    end
    @(negedge clk1);
    #1;
    total++;
    if (out_valid !== 1'b1 || out_ir !== 32'h1000_0000 || out_npc !== 32'h401) begin
      bad++; $display("FAIL wrap_d1 got=%0b/%0h/%0h want=1/10000000/401", out_valid, out_ir, out_npc);
    end
    @(negedge clk1);
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b1;
    repeat (5) @(negedge clk1);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0 || out_ir !== 32'd0 || out_npc !== 32'd0 ||
        fetch_pc !== 32'd0 || imem_addr !== 10'd0) begin
      bad++; $display("FAIL arst_outputs got=%0b/%0b/%0h/%0h/%0h/%0h want=all 0",
                      imem_req, out_valid, out_ir, out_npc, fetch_pc, imem_addr);
    end
    @(negedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 10'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL arst_restart got=%0b/%0h/%0b want=1/0/0", imem_req, imem_addr, out_valid);
    end
    @(negedge clk1);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_no_residual got=%0b want=0", out_valid); end
    @(negedge clk1);
    #1;
    total++;
    if (out_valid !== 1'b1 || out_ir !== 32'h1000_0000 || out_npc !== 32'd1) begin
      bad++; $display("FAIL arst_first got=%0b/%0h/%0h want=1/10000000/1", out_valid, out_ir, out_npc);
    end
    @(negedge clk1);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
